// File: rtl/fcl_ctrl_pkg.sv
// Shared types and helpers for the fully-connected-layer control FSM.
// One-hot state encoding plus default frame/filter counts.
package fcl_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_WRITE = 4'b0010,
        S_READ  = 4'b0100,
        S_DONE  = 4'b1000
    } state_t;

    localparam int DEF_FRAMES  = 5;
    localparam int DEF_FILTERS = 120;

    function automatic int clog2_min1(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/fcl_wrap_cnt.sv
// Wrapping up-counter with synchronous clear and a terminal-value flag.
// Wraps by explicit compare to TERM rather than natural overflow.
module fcl_wrap_cnt #(
    parameter int W    = 3,
    parameter int TERM = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         last
);

    assign last = (cnt == W'(TERM));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= last ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/fsm_fcl_ctrl.sv
// Control FSM for a fully-connected layer: sequences SRAM buffer fills
// and per-filter reads, owning its own frame-address and filter counters.
module fsm_fcl_ctrl
    import fcl_ctrl_pkg::*;
#(
    parameter int FRAMES_PER_BURST = DEF_FRAMES,
    parameter int NUM_FILTERS      = DEF_FILTERS,
    parameter int REUSE_INPUT      = 0,
    parameter int ADDR_W           = clog2_min1(FRAMES_PER_BURST),
    parameter int FILT_W           = clog2_min1(NUM_FILTERS)
) (
    input  logic              fsm_clk,
    input  logic              fsm_rst,
    input  logic              wake_i,
    input  logic              restart_i,
    input  logic              in_valid_i,
    input  logic              rd_ready_i,
    output logic              sram_wr_en_o,
    output logic              sram_rd_en_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [FILT_W-1:0] filt_idx_o,
    output logic              fcl_cnt_en_o,
    output logic              fcl_ld_o,
    output logic              busy_o,
    output logic              done_o
);

    state_t              state_q;
    state_t              state_d;
    logic                first_q;
    logic [ADDR_W-1:0]   addr;
    logic [FILT_W-1:0]   filt;
    logic                addr_last;
    logic                filt_last;
    logic                addr_en;
    logic                filt_en;
    logic                cnt_clr;

    fcl_wrap_cnt #(
        .W    (ADDR_W),
        .TERM (FRAMES_PER_BURST - 1)
    ) u_addr_cnt (
        .clk  (fsm_clk),
        .rst  (fsm_rst),
        .clr  (cnt_clr),
        .en   (addr_en),
        .cnt  (addr),
        .last (addr_last)
    );

    fcl_wrap_cnt #(
        .W    (FILT_W),
        .TERM (NUM_FILTERS - 1)
    ) u_filt_cnt (
        .clk  (fsm_clk),
        .rst  (fsm_rst),
        .clr  (cnt_clr),
        .en   (filt_en),
        .cnt  (filt),
        .last (filt_last)
    );

    // first_q marks the first cycle spent in DONE so done_o is a single pulse
    always_ff @(posedge fsm_clk) begin
        if (fsm_rst) begin
            state_q <= S_IDLE;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= (state_q != S_DONE);
        end
    end

    always_comb begin
        state_d      = state_q;
        sram_wr_en_o = 1'b0;
        sram_rd_en_o = 1'b0;
        sram_addr_o  = addr;
        filt_idx_o   = filt;
        fcl_cnt_en_o = 1'b0;
        fcl_ld_o     = 1'b0;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        addr_en      = 1'b0;
        filt_en      = 1'b0;
        cnt_clr      = 1'b0;
        if (restart_i) begin
            state_d     = S_IDLE;
            cnt_clr     = 1'b1;
            sram_addr_o = '0;
            filt_idx_o  = '0;
        end else begin
            unique case (1'b1)
                (state_q == S_IDLE): begin
                    fcl_ld_o = 1'b1;
                    if (wake_i) state_d = S_WRITE;
                end
                (state_q == S_WRITE): begin
                    busy_o       = 1'b1;
                    sram_wr_en_o = in_valid_i;
                    addr_en      = in_valid_i;
                    if (in_valid_i && addr_last) state_d = S_READ;
                end
                (state_q == S_READ): begin
                    busy_o       = 1'b1;
                    sram_rd_en_o = rd_ready_i;
                    addr_en      = rd_ready_i;
                    if (rd_ready_i && addr_last) begin
                        fcl_cnt_en_o = 1'b1;
                        filt_en      = 1'b1;
                        if (filt_last) begin
                            state_d = S_DONE;
                        end else if (REUSE_INPUT != 0) begin
                            state_d = S_READ;
                        end else begin
                            state_d = S_WRITE;
                        end
                    end
                end
                (state_q == S_DONE): begin
                    done_o = first_q;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

endmodule
